pipelined_carry_bypass_adder: RTL and testbench

- Parametrised, pipelined carry-bypass adder/subtractor for the datapath ALU.
- The operand is split into BLK-bit ripple blocks. Each block has a propagate-all bypass mux on its carry-out.
- The blocks are grouped into PIPE register stages.
- Valid/ready handshake on both sides; add/sub and borrow chaining are selected per transaction.

---
 rtl/pipelined_carry_bypass_adder.sv | 193 +++++++++++++++++++
 tb/tb_pipelined_carry_bypass_adder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_bypass_adder.sv
// rtl/pipelined_carry_bypass_adder.sv - pipelined carry-bypass adder/subtractor with valid/ready handshake
//
// Purpose:
//   Adds or subtracts two WIDTH-bit operands using BLK-bit ripple blocks.
//   Each block has a propagate-all bypass mux on its carry-out. The blocks
//   are spread over PIPE register stages, which moves the pipeline in
//   lockstep. Latency is PIPE cycles and throughput is one result per cycle.
//
// Parameters:
//   WIDTH - operand/sum width (multiple of BLK)
//   BLK   - bits per ripple block
//   PIPE  - register stages / latency (1..WIDTH/BLK, divides WIDTH/BLK)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand transaction present
//   in_ready   adder accepts a transaction this cycle
//   a, b       operands
//   cin        carry-in (add) or borrow-in (sub)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result present
//   out_ready  consumer accepts the result
//   sum        result
//   cout       carry-out; on subtract, 1 means no borrow
//   overflow   signed two's-complement overflow
//   sat        (CBA_SATURATE_EN only) clamp sum on overflow
//
// Optional feature macro: CBA_SATURATE_EN
module pipelined_carry_bypass_adder #(
    parameter int WIDTH = 32,
    parameter int BLK   = 4,
    parameter int PIPE  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef CBA_SATURATE_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    // Blocks handled per stage, and the index of the output stage.
    localparam int NB   = WIDTH / (BLK * PIPE);
    localparam int LAST = PIPE - 1;

    // Subtraction is a + ~b + ~borrow.
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? ~cin : cin;

    logic stall;

    // Per-stage registers. a_q/b_q keep the full operand so the top bits
    // double as the registered sign bits at the final stage.
    logic [PIPE-1:0]  valid_q;
    logic [PIPE-1:0]  valid_d;
    logic [PIPE-1:0]  c_q;
    logic [PIPE-1:0]  c_d;
    logic [WIDTH-1:0] a_q   [PIPE];
    logic [WIDTH-1:0] b_q   [PIPE];
    logic [WIDTH-1:0] sum_q [PIPE];
    logic [WIDTH-1:0] sum_d [PIPE];

    // Stage inputs: stage 0 sees the conditioned operands, later stages
    // see the registers of the stage before.
    logic [PIPE-1:0]  st_c;
    logic [WIDTH-1:0] st_a   [PIPE];
    logic [WIDTH-1:0] st_b   [PIPE];
    logic [WIDTH-1:0] st_sum [PIPE];

`ifdef CBA_SATURATE_EN
    logic [PIPE-1:0] sat_q;
    logic [PIPE-1:0] sat_d;
`endif

    for (genvar k = 0; k < PIPE; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign st_a[k]    = a;
            assign st_b[k]    = b_eff;
            assign st_sum[k]  = '0;
            assign st_c[k]    = c0;
            assign valid_d[k] = in_valid;
`ifdef CBA_SATURATE_EN
            assign sat_d[k]   = sat;
`endif
        end else begin : g_next
            assign st_a[k]    = a_q[k-1];
            assign st_b[k]    = b_q[k-1];
            assign st_sum[k]  = sum_q[k-1];
            assign st_c[k]    = c_q[k-1];
            assign valid_d[k] = valid_q[k-1];
`ifdef CBA_SATURATE_EN
            assign sat_d[k]   = sat_q[k-1];
`endif
        end

        // Lowest bit index processed by this stage.
        localparam int LO = k * NB * BLK;

        logic [WIDTH-1:0] sum_c;
        logic             carry_c;
        logic             rc;
        logic             allp;
        logic             p;
        int               idx;

        always_comb begin
            sum_c   = st_sum[k];
            carry_c = st_c[k];
            rc      = 1'b0;
            allp    = 1'b0;
            p       = 1'b0;
            idx     = 0;
            for (int j = 0; j < NB; j++) begin
                rc   = carry_c;
                allp = 1'b1;
                for (int i = 0; i < BLK; i++) begin
                    idx        = LO + j * BLK + i;
                    p          = st_a[k][idx] ^ st_b[k][idx];
                    sum_c[idx] = p ^ rc;
                    rc         = (st_a[k][idx] & st_b[k][idx]) | (p & rc);
                    allp       = allp & p;
                end
                // When every bit propagates, the block carry-in skips the
                // ripple chain entirely.
                carry_c = allp ? carry_c : rc;
            end
        end

        assign sum_d[k] = sum_c;
        assign c_d[k]   = carry_c;
    end

    // Lockstep shift: the whole pipeline moves or the whole pipeline holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            c_q     <= '0;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            sum_q   <= '{default: '0};
`ifdef CBA_SATURATE_EN
            sat_q   <= '0;
`endif
        end else if (!stall) begin
            valid_q <= valid_d;
            c_q     <= c_d;
            a_q     <= st_a;
            b_q     <= st_b;
            sum_q   <= sum_d;
`ifdef CBA_SATURATE_EN
            sat_q   <= sat_d;
`endif
        end
    end

    logic [WIDTH-1:0] sum_raw;
    logic             a_msb;
    logic             b_msb;

    assign sum_raw   = sum_q[LAST];
    assign a_msb     = a_q[LAST][WIDTH-1];
    assign b_msb     = b_q[LAST][WIDTH-1];
    assign overflow  = (a_msb == b_msb) && (sum_raw[WIDTH-1] != a_msb);
    assign cout      = c_q[LAST];
    assign out_valid = valid_q[LAST];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

`ifdef CBA_SATURATE_EN
    // Same-sign operands overflow toward their own sign: clamp to the
    // largest magnitude of that sign.
    assign sum = (sat_q[LAST] && overflow)
               ? (a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
               : sum_raw;
`else
    assign sum = sum_raw;
`endif

endmodule

// File: tb/tb_pipelined_carry_bypass_adder.sv
// tb/tb_pipelined_carry_bypass_adder.sv - self-checking bench for pipelined_carry_bypass_adder
module tb_pipelined_carry_bypass_adder;

    localparam int W   = 32;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
`ifdef CBA_SATURATE_EN
    logic         sat;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t sb[$];

    pipelined_carry_bypass_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef CBA_SATURATE_EN
        .sat       (sat),
`endif
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(logic [W-1:0] ma, logic [W-1:0] mb, logic mc, logic ms, logic msat);
        logic [W:0] r;
        exp_t       e;
        if (!ms) begin
            r      = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
            e.cout = r[W];
            e.ovf  = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
        end else begin
            r      = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mc};
            e.cout = !r[W];
            e.ovf  = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
        end
        e.sum = r[W-1:0];
        if (msat && e.ovf)
            e.sum = ma[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (sum !== '0) begin n_err++; $display("FAIL reset_sum: got %h want 0", sum); end
        n_vec++; if (cout !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL reset_flags: got cout=%b ovf=%b want 0 0", cout, overflow); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        @(negedge clk); rst_n = 1'b1;
        // Two transactions in flight, then reset asserted away from the clock edge.
        @(negedge clk); in_valid = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111;
        @(negedge clk); a = 32'hDEAD_BEEF; b = 32'h0000_0001;
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL midstream_inflight: got out_valid=%b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || sum !== '0) begin n_err++; $display("FAIL midreset_clear: got out_valid=%b sum=%h want 0 0", out_valid, sum); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midreset_in_ready: got %b want 1", in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stale_result cycle %0d: got out_valid=%b want 0", c, out_valid); end
        end
        sb.delete();
    endtask

    task automatic test_full_bypass();
        exp_t e;
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'h0; cin = 1'b1; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bypass_in_ready: got %b want 1", in_ready); end
        sb.push_back(model(a, b, cin, sub, 1'b0));
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk); in_valid = 1'b0; #1;
            n_vec++;
            if (out_valid !== (c == LAT)) begin n_err++; $display("FAIL bypass_latency cycle %0d: got out_valid=%b want %b", c, out_valid, (c == LAT)); end
        end
        if (out_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            if ({sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
                n_err++; $display("FAIL bypass_result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", sum, cout, overflow, e.sum, e.cout, e.ovf);
            end
        end
        sb.delete();
    endtask

    task automatic test_subtract();
        logic [W-1:0] va[2];
        logic [W-1:0] vb[2];
        logic         vc[2];
        exp_t         e;
        bit           seen;
        va[0] = 32'h8000_0000; vb[0] = 32'h0000_0001; vc[0] = 1'b0;
        va[1] = 32'h0000_0000; vb[1] = 32'h0000_0000; vc[1] = 1'b1;
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            a = va[v]; b = vb[v]; cin = vc[v]; sub = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            if (in_ready === 1'b1) sb.push_back(model(a, b, cin, sub, 1'b0));
            seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                @(negedge clk); in_valid = 1'b0; #1;
                if (out_valid === 1'b1) begin
                    seen = 1'b1;
                    n_vec++;
                    if (sb.size() == 0) begin
                        n_err++; $display("FAIL sub_%0d: got unexpected result sum=%h, want none", v, sum);
                    end else begin
                        e = sb.pop_front();
                        if ({sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
                            n_err++; $display("FAIL sub_%0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", v, sum, cout, overflow, e.sum, e.cout, e.ovf);
                        end
                    end
                end
            end
            if (!seen) begin n_vec++; n_err++; $display("FAIL sub_%0d_timeout: got no result, want one within 8 cycles", v); end
        end
        sb.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   sent = 0;
        int   got  = 0;
        int   c    = 0;
        while (got < 12 && c < 40) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (sent < 12) begin
                in_valid = 1'b1; a = $urandom; b = $urandom;
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= LAT && c < 12 + LAT) begin
                n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_throughput cycle %0d: got out_valid=%b want 1", c, out_valid); end
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL b2b_extra: got sum=%h, want no result", sum);
                end else begin
                    e = sb.pop_front();
                    if ({sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
                        n_err++; $display("FAIL b2b_result %0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", got, sum, cout, overflow, e.sum, e.cout, e.ovf);
                    end
                end
                got++;
            end
            if (in_valid && in_ready === 1'b1) begin
                sb.push_back(model(a, b, cin, sub, 1'b0));
                sent++;
            end
            c++;
        end
        n_vec++; if (got != 12) begin n_err++; $display("FAIL b2b_count: got %0d results want 12", got); end
        sb.delete();
        @(negedge clk); in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t         e;
        int           sent = 0;
        int           got  = 0;
        int           c    = 0;
        bit           prev_stall = 1'b0;
        logic [W-1:0] prev_sum = '0;
        logic         prev_cout = 1'b0;
        while (got < 5 && c < 40) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c < 6);
            if (sent < 5 && !(in_valid && !in_ready)) begin
                in_valid = 1'b1; a = $urandom; b = $urandom;
                cin = 1'($urandom_range(0, 1)); sub = 1'b0;
            end else if (sent >= 5) begin
                in_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || sum !== prev_sum || cout !== prev_cout) begin
                    n_err++; $display("FAIL bp_hold cycle %0d: got valid=%b sum=%h cout=%b want 1 %h %b", c, out_valid, sum, cout, prev_sum, prev_cout);
                end
            end
            if (out_valid === 1'b1 && !out_ready) begin
                n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cycle %0d: got %b want 0", c, in_ready); end
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_sum   = sum;
            prev_cout  = cout;
            if (out_valid === 1'b1 && out_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL bp_duplicate: got sum=%h, want no result", sum);
                end else begin
                    e = sb.pop_front();
                    if ({sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
                        n_err++; $display("FAIL bp_result %0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", got, sum, cout, overflow, e.sum, e.cout, e.ovf);
                    end
                end
                got++;
            end
            if (in_valid && in_ready === 1'b1) begin
                sb.push_back(model(a, b, cin, sub, 1'b0));
                sent++;
            end
            c++;
        end
        n_vec++; if (got != 5 || sb.size() != 0) begin n_err++; $display("FAIL bp_count: got %0d results, %0d pending want 5, 0", got, sb.size()); end
        sb.delete();
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    endtask

`ifdef CBA_SATURATE_EN
    task automatic test_saturate();
        exp_t e;
        bit   seen;
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            a = 32'h7FFF_FFFF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0;
            sat = (v == 0); in_valid = 1'b1; out_ready = 1'b1;
            #1;
            if (in_ready === 1'b1) sb.push_back(model(a, b, cin, sub, sat));
            seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                @(negedge clk); in_valid = 1'b0; #1;
                if (out_valid === 1'b1) begin
                    seen = 1'b1;
                    n_vec++;
                    e = (sb.size() > 0) ? sb.pop_front() : '0;
                    if ({sum, cout, overflow} !== {e.sum, e.cout, e.ovf}) begin
                        n_err++; $display("FAIL sat_%0d: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b", v, sum, cout, overflow, e.sum, e.cout, e.ovf);
                    end
                end
            end
            if (!seen) begin n_vec++; n_err++; $display("FAIL sat_%0d_timeout: got no result, want one within 8 cycles", v); end
        end
        sb.delete();
        sat = 1'b0;
    endtask
`endif

    initial begin
`ifdef CBA_SATURATE_EN
        sat = 1'b0;
`endif
        test_reset();
        test_full_bypass();
        test_subtract();
        test_back_to_back();
        test_backpressure();
`ifdef CBA_SATURATE_EN
        test_saturate();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, want finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
